// File: rtl/ofdm_frame_buf_ctrl.sv
// Frame buffer controller for a single-port BSRAM: fills one OFDM frame from the sample
// front-end, then streams it out in address order over valid/ready through a 2-entry FIFO.
module ofdm_frame_buf_ctrl #(
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 10,
    parameter int FRAME_LEN = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    input  logic              out_ready,
    output logic              frame_done,
    output logic              ram_ce,
    output logic              ram_oce,
    output logic              ram_wre,
    output logic [ADDR_W-1:0] ram_ad,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout
);

    localparam int              CNT_W  = ADDR_W + 1;
    localparam logic [CNT_W-1:0] LEN_C  = CNT_W'(FRAME_LEN);
    localparam logic [CNT_W-1:0] LAST_C = CNT_W'(FRAME_LEN - 1);
    localparam logic [CNT_W-1:0] ONE_C  = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] wr_cnt_reg, wr_cnt_next;
    logic [CNT_W-1:0] rd_cnt_reg, rd_cnt_next;
    logic             armed_reg;
    logic             inflight_reg;
    logic             inflight_last_reg;
    logic             wr_ptr_reg;
    logic             rd_ptr_reg;
    logic [1:0]       fifo_cnt_reg;
    logic             frame_done_reg;

    logic             wr_en;
    logic             rd_issue;
    logic             push;
    logic             pop;
    logic             head_last;
    logic [2:0]       occ_after_pop;

    assign push          = inflight_reg;
    assign out_valid     = (fifo_cnt_reg != 2'd0);
    assign pop           = out_valid && out_ready;
    assign occ_after_pop = {1'b0, fifo_cnt_reg} + {2'b00, inflight_reg} - {2'b00, pop};

    always_comb begin
        state_next  = state_reg;
        wr_cnt_next = wr_cnt_reg;
        rd_cnt_next = rd_cnt_reg;
        in_ready    = 1'b0;
        wr_en       = 1'b0;
        rd_issue    = 1'b0;

        case (state_reg)
            IDLE: begin
                in_ready = armed_reg && !flush;
                if (in_valid && in_ready) begin
                    wr_en       = 1'b1;
                    wr_cnt_next = ONE_C;
                    state_next  = FILL;
                end
            end
            FILL: begin
                in_ready = armed_reg && !flush;
                if (in_valid && in_ready) begin
                    wr_en       = 1'b1;
                    wr_cnt_next = wr_cnt_reg + ONE_C;
                    if (wr_cnt_reg == LAST_C) begin
                        state_next  = DRAIN;
                        rd_cnt_next = '0;
                    end
                end
            end
            DRAIN: begin
                // Keep FIFO occupancy plus the read in flight within the two FIFO slots.
                if (!flush && (rd_cnt_reg < LEN_C) && (occ_after_pop < 3'd2)) begin
                    rd_issue    = 1'b1;
                    rd_cnt_next = rd_cnt_reg + ONE_C;
                end
                if (pop && head_last) begin
                    state_next  = IDLE;
                    wr_cnt_next = '0;
                    rd_cnt_next = '0;
                end
            end
            default: state_next = IDLE;
        endcase

        if (flush) begin
            state_next  = IDLE;
            wr_cnt_next = '0;
            rd_cnt_next = '0;
        end
    end

    assign ram_oce = 1'b1;
    assign ram_ce  = wr_en || rd_issue;
    assign ram_wre = wr_en;
    assign ram_din = wr_en ? in_data : '0;
    assign ram_ad  = rd_issue ? rd_cnt_reg[ADDR_W-1:0] :
                     (wr_en ? wr_cnt_reg[ADDR_W-1:0] : '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg         <= IDLE;
            wr_cnt_reg        <= '0;
            rd_cnt_reg        <= '0;
            armed_reg         <= 1'b0;
            inflight_reg      <= 1'b0;
            inflight_last_reg <= 1'b0;
            wr_ptr_reg        <= 1'b0;
            rd_ptr_reg        <= 1'b0;
            fifo_cnt_reg      <= 2'd0;
            frame_done_reg    <= 1'b0;
        end else begin
            state_reg      <= state_next;
            wr_cnt_reg     <= wr_cnt_next;
            rd_cnt_reg     <= rd_cnt_next;
            armed_reg      <= 1'b1;
            frame_done_reg <= (state_reg == DRAIN) && pop && head_last && !flush;
            if (flush) begin
                inflight_reg      <= 1'b0;
                inflight_last_reg <= 1'b0;
                wr_ptr_reg        <= 1'b0;
                rd_ptr_reg        <= 1'b0;
                fifo_cnt_reg      <= 2'd0;
            end else begin
                inflight_reg      <= rd_issue;
                inflight_last_reg <= rd_issue && (rd_cnt_reg == LAST_C);
                if (push) begin
                    wr_ptr_reg <= ~wr_ptr_reg;
                end
                if (pop) begin
                    rd_ptr_reg <= ~rd_ptr_reg;
                end
                fifo_cnt_reg <= fifo_cnt_reg + {1'b0, push} - {1'b0, pop};
            end
        end
    end

    // RAM read data is captured the cycle after issue, which gives the 2-cycle issue latency.
    for (genvar gi = 0; gi < 2; gi++) begin : g_fifo
        logic [DATA_W-1:0] data_reg;
        logic              last_reg;
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                data_reg <= '0;
                last_reg <= 1'b0;
            end else if (push && !flush && (wr_ptr_reg == 1'(gi))) begin
                data_reg <= ram_dout;
                last_reg <= inflight_last_reg;
            end
        end
    end

    assign out_data   = rd_ptr_reg ? g_fifo[1].data_reg : g_fifo[0].data_reg;
    assign head_last  = rd_ptr_reg ? g_fifo[1].last_reg : g_fifo[0].last_reg;
    assign out_last   = out_valid && head_last;
    assign frame_done = frame_done_reg;

endmodule

// File: tb/tb_ofdm_frame_buf_ctrl.sv
// Directed bench for ofdm_frame_buf_ctrl: an 8-sample instance for the handshake scenarios
// and a 1024-sample instance for full-depth addressing, each with a behavioural RAM.
`timescale 1ns/1ps
module tb_ofdm_frame_buf_ctrl;

    localparam int DW = 16;
    localparam int AW = 10;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    // ---------------- small instance (FRAME_LEN = 8) ----------------
    logic          s_rst, s_flush, s_in_valid, s_in_ready, s_out_valid, s_out_last;
    logic          s_out_ready, s_frame_done, s_ram_ce, s_ram_oce, s_ram_wre;
    logic [DW-1:0] s_in_data, s_out_data, s_ram_din, s_ram_dout;
    logic [AW-1:0] s_ram_ad;

    ofdm_frame_buf_ctrl #(.DATA_W(DW), .ADDR_W(AW), .FRAME_LEN(8)) u_dut_s (
        .clk(clk), .reset(s_rst), .flush(s_flush),
        .in_valid(s_in_valid), .in_data(s_in_data), .in_ready(s_in_ready),
        .out_valid(s_out_valid), .out_data(s_out_data), .out_last(s_out_last),
        .out_ready(s_out_ready), .frame_done(s_frame_done),
        .ram_ce(s_ram_ce), .ram_oce(s_ram_oce), .ram_wre(s_ram_wre),
        .ram_ad(s_ram_ad), .ram_din(s_ram_din), .ram_dout(s_ram_dout)
    );

    logic [DW-1:0] s_mem [1024];
    always @(posedge clk) begin
        if (s_ram_ce) begin
            if (s_ram_wre) s_mem[s_ram_ad] <= s_ram_din;
            else           s_ram_dout      <= s_mem[s_ram_ad];
        end
    end

    logic          s_clr_req = 1'b0;
    logic          s_clr_ack = 1'b0;
    logic          s_drain_chk = 1'b0;
    int            s_cyc = 0;
    logic [AW-1:0] s_wr_q [$];
    logic [DW:0]   s_out_q [$];
    int            s_fd_cnt = 0, s_fd_cyc = 0, s_last_wr_cyc = 0, s_first_ov_cyc = -1;
    int            s_first_hs_cyc = -1, s_last_hs_cyc = 0, s_hold_viol = 0, s_rdy_viol = 0;
    logic          s_hold_pend = 1'b0;
    logic [DW:0]   s_hold_val = '0;

    always @(negedge clk) begin
        s_cyc++;
        if (s_clr_req != s_clr_ack) begin
            s_wr_q.delete();
            s_out_q.delete();
            s_fd_cnt = 0; s_fd_cyc = 0; s_last_wr_cyc = 0; s_first_ov_cyc = -1;
            s_first_hs_cyc = -1; s_last_hs_cyc = 0; s_hold_viol = 0; s_rdy_viol = 0;
            s_clr_ack = s_clr_req;
        end
        if (s_rst) begin
            s_hold_pend = 1'b0;
        end else begin
            if (s_ram_ce && s_ram_wre) begin
                s_wr_q.push_back(s_ram_ad);
                s_last_wr_cyc = s_cyc;
            end
            if (s_out_valid && s_first_ov_cyc < 0) s_first_ov_cyc = s_cyc;
            if (s_hold_pend && (!s_out_valid || {s_out_last, s_out_data} != s_hold_val))
                s_hold_viol++;
            s_hold_pend = s_out_valid && !s_out_ready;
            s_hold_val  = {s_out_last, s_out_data};
            if (s_out_valid && s_out_ready) begin
                s_out_q.push_back({s_out_last, s_out_data});
                if (s_first_hs_cyc < 0) s_first_hs_cyc = s_cyc;
                s_last_hs_cyc = s_cyc;
            end
            if (s_frame_done) begin
                s_fd_cnt++;
                s_fd_cyc = s_cyc;
            end
            if (s_drain_chk && s_in_ready) s_rdy_viol++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic s_clear();
        s_clr_req = ~s_clr_req;
    endtask

    task automatic s_push(input logic [DW-1:0] d);
        int n = 0;
        s_in_valid = 1'b1;
        s_in_data  = d;
        while (!s_in_ready && n < 50) begin
            step();
            n++;
        end
        if (!s_in_ready) check_eq("s_push_timeout", 32'(s_in_ready), 32'd1);
        step();
        s_in_valid = 1'b0;
        s_in_data  = '0;
    endtask

    task automatic s_fill(input logic [DW-1:0] base, input int gap);
        for (int i = 0; i < 8; i++) begin
            repeat (gap) step();
            s_push(base + DW'(i));
        end
    endtask

    // mode 0: out_ready held high; mode 1: out_ready pattern 1,0,0 repeating
    task automatic s_drain(input int mode, input logic hold_in_valid);
        int k = 0;
        s_drain_chk = hold_in_valid;
        s_in_valid  = hold_in_valid;
        s_in_data   = 16'hDEAD;
        while (s_out_q.size() < 8 && k < 200) begin
            s_out_ready = (mode == 0) ? 1'b1 : ((k % 3) == 0);
            step();
            k++;
        end
        s_drain_chk = 1'b0;
        s_in_valid  = 1'b0;
        s_in_data   = '0;
        s_out_ready = 1'b0;
        if (s_out_q.size() < 8) check_eq("s_drain_timeout", 32'(s_out_q.size()), 32'd8);
        step();
        step();
    endtask

    task automatic s_check_frame(input string tag, input logic [DW-1:0] base);
        int bad_out = 0;
        int bad_wr  = 0;
        logic [DW:0] e;
        for (int i = 0; i < s_out_q.size(); i++) begin
            e = {(i == 7), base + DW'(i)};
            if (s_out_q[i] !== e) bad_out++;
        end
        for (int i = 0; i < s_wr_q.size(); i++) begin
            if (s_wr_q[i] !== AW'(i)) bad_wr++;
        end
        $display("frame %s: %0d outputs, %0d writes, %0d frame_done", tag,
                 s_out_q.size(), s_wr_q.size(), s_fd_cnt);
        check_eq({tag, "_out_count"}, 32'(s_out_q.size()), 32'd8);
        check_eq({tag, "_out_data"}, 32'(bad_out), 32'd0);
        check_eq({tag, "_wr_count"}, 32'(s_wr_q.size()), 32'd8);
        check_eq({tag, "_wr_addr"}, 32'(bad_wr), 32'd0);
        check_eq({tag, "_frame_done"}, 32'(s_fd_cnt), 32'd1);
    endtask

    // ---------------- large instance (FRAME_LEN = 1024) ----------------
    logic          l_rst, l_flush, l_in_valid, l_in_ready, l_out_valid, l_out_last;
    logic          l_out_ready, l_frame_done, l_ram_ce, l_ram_oce, l_ram_wre;
    logic [DW-1:0] l_in_data, l_out_data, l_ram_din, l_ram_dout;
    logic [AW-1:0] l_ram_ad;

    ofdm_frame_buf_ctrl #(.DATA_W(DW), .ADDR_W(AW), .FRAME_LEN(1024)) u_dut_l (
        .clk(clk), .reset(l_rst), .flush(l_flush),
        .in_valid(l_in_valid), .in_data(l_in_data), .in_ready(l_in_ready),
        .out_valid(l_out_valid), .out_data(l_out_data), .out_last(l_out_last),
        .out_ready(l_out_ready), .frame_done(l_frame_done),
        .ram_ce(l_ram_ce), .ram_oce(l_ram_oce), .ram_wre(l_ram_wre),
        .ram_ad(l_ram_ad), .ram_din(l_ram_din), .ram_dout(l_ram_dout)
    );

    logic [DW-1:0] l_mem [1024];
    always @(posedge clk) begin
        if (l_ram_ce) begin
            if (l_ram_wre) l_mem[l_ram_ad] <= l_ram_din;
            else           l_ram_dout      <= l_mem[l_ram_ad];
        end
    end

    int l_wr_n = 0, l_wr_bad = 0, l_rd_n = 0, l_rd_bad = 0;
    int l_out_n = 0, l_out_bad = 0, l_fd_cnt = 0;

    always @(negedge clk) begin
        if (!l_rst) begin
            if (l_ram_ce && l_ram_wre) begin
                if (l_ram_ad !== AW'(l_wr_n) || l_ram_din !== DW'(l_wr_n)) l_wr_bad++;
                l_wr_n++;
            end
            if (l_ram_ce && !l_ram_wre) begin
                if (l_ram_ad !== AW'(l_rd_n)) l_rd_bad++;
                l_rd_n++;
            end
            if (l_out_valid && l_out_ready) begin
                if (l_out_data !== DW'(l_out_n) || l_out_last !== (l_out_n == 1023)) l_out_bad++;
                l_out_n++;
            end
            if (l_frame_done) l_fd_cnt++;
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        s_rst = 1'b1; s_flush = 1'b0; s_in_valid = 1'b1; s_in_data = 16'h1234; s_out_ready = 1'b0;
        l_rst = 1'b1; l_flush = 1'b0; l_in_valid = 1'b0; l_in_data = '0; l_out_ready = 1'b0;
        repeat (3) step();

        check_eq("rst_in_ready",   32'(s_in_ready),   32'd0);
        check_eq("rst_out_valid",  32'(s_out_valid),  32'd0);
        check_eq("rst_out_last",   32'(s_out_last),   32'd0);
        check_eq("rst_frame_done", 32'(s_frame_done), 32'd0);
        check_eq("rst_ram_ce",     32'(s_ram_ce),     32'd0);
        check_eq("rst_ram_wre",    32'(s_ram_wre),    32'd0);
        check_eq("rst_ram_ad",     32'(s_ram_ad),     32'd0);
        check_eq("rst_ram_din",    32'(s_ram_din),    32'd0);
        check_eq("rst_ram_oce",    32'(s_ram_oce),    32'd1);

        s_rst = 1'b0;
        #1;
        check_eq("pre_clk_in_ready", 32'(s_in_ready), 32'd0);
        check_eq("pre_clk_ram_ce",   32'(s_ram_ce),   32'd0);
        s_in_valid = 1'b0;
        s_in_data  = '0;
        step();
        check_eq("armed_in_ready", 32'(s_in_ready), 32'd1);

        // 1) straight frame, out_ready held high
        s_clear();
        s_fill(16'h0000, 0);
        s_drain(0, 1'b0);
        s_check_frame("t1", 16'h0000);
        check_eq("t1_latency",  32'(s_first_ov_cyc - s_last_wr_cyc), 32'd3);
        check_eq("t1_thruput",  32'(s_last_hs_cyc - s_first_hs_cyc), 32'd7);
        check_eq("t1_done_lag", 32'(s_fd_cyc - s_last_hs_cyc),       32'd1);

        // 2) out_ready 1,0,0 pattern: order preserved, data held while stalled
        s_clear();
        s_fill(16'h0020, 0);
        s_drain(1, 1'b0);
        s_check_frame("t2", 16'h0020);
        check_eq("t2_hold_stable", 32'(s_hold_viol), 32'd0);

        // 3) in_valid 1 of 3 cycles; in_valid held high during DRAIN
        s_clear();
        s_fill(16'h0040, 2);
        s_drain(0, 1'b1);
        s_check_frame("t3", 16'h0040);
        check_eq("t3_ready_in_drain", 32'(s_rdy_viol), 32'd0);

        // 4) flush together with in_valid after 5 writes
        s_clear();
        for (int i = 0; i < 5; i++) s_push(DW'(i));
        s_in_valid = 1'b1;
        s_in_data  = 16'h0055;
        s_flush    = 1'b1;
        #1;
        check_eq("t4_flush_ready", 32'(s_in_ready), 32'd0);
        check_eq("t4_flush_ce",    32'(s_ram_ce),   32'd0);
        step();
        s_flush    = 1'b0;
        s_in_valid = 1'b0;
        s_in_data  = '0;
        step();
        check_eq("t4_writes_before_flush", 32'(s_wr_q.size()), 32'd5);
        check_eq("t4_no_frame_done",       32'(s_fd_cnt),      32'd0);
        s_clear();
        s_fill(16'h0100, 0);
        s_drain(0, 1'b0);
        s_check_frame("t4", 16'h0100);

        // 5) asynchronous reset mid-DRAIN after 3 outputs
        s_clear();
        s_fill(16'h0010, 0);
        s_out_ready = 1'b1;
        for (int k = 0; k < 50 && s_out_q.size() < 3; k++) step();
        check_eq("t5_three_out", 32'(s_out_q.size()), 32'd3);
        s_rst = 1'b1;
        #1;
        check_eq("t5_rst_out_valid", 32'(s_out_valid), 32'd0);
        check_eq("t5_rst_out_last",  32'(s_out_last),  32'd0);
        check_eq("t5_rst_ram_ce",    32'(s_ram_ce),    32'd0);
        check_eq("t5_rst_in_ready",  32'(s_in_ready),  32'd0);
        s_out_ready = 1'b0;
        step();
        step();
        s_rst = 1'b0;
        step();
        s_clear();
        s_fill(16'h00A0, 0);
        s_drain(0, 1'b0);
        s_check_frame("t5", 16'h00A0);

        // 6) full 1024-sample frame
        l_rst = 1'b0;
        step();
        for (int i = 0; i < 1024; i++) begin
            int n = 0;
            l_in_valid = 1'b1;
            l_in_data  = DW'(i);
            while (!l_in_ready && n < 50) begin
                step();
                n++;
            end
            if (!l_in_ready) check_eq("l_push_timeout", 32'(l_in_ready), 32'd1);
            step();
        end
        l_in_valid  = 1'b0;
        l_in_data   = '0;
        l_out_ready = 1'b1;
        for (int k = 0; k < 3000 && l_out_n < 1024; k++) step();
        step();
        step();
        $display("frame t6: %0d writes, %0d reads, %0d outputs, %0d frame_done",
                 l_wr_n, l_rd_n, l_out_n, l_fd_cnt);
        check_eq("t6_wr_count",   32'(l_wr_n),    32'd1024);
        check_eq("t6_wr_seq",     32'(l_wr_bad),  32'd0);
        check_eq("t6_rd_count",   32'(l_rd_n),    32'd1024);
        check_eq("t6_rd_seq",     32'(l_rd_bad),  32'd0);
        check_eq("t6_out_count",  32'(l_out_n),   32'd1024);
        check_eq("t6_out_data",   32'(l_out_bad), 32'd0);
        check_eq("t6_frame_done", 32'(l_fd_cnt),  32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
